// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared size encodings, FSM states and latency constants for the load/store unit
package lsu_pkg;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RMW_RD = 3'd2,
        WR     = 3'd3,
        RESP   = 3'd4
    } lsu_state_e;

    // Cycles from accept to first rsp_valid
    localparam int LAT_LOAD      = 2;
    localparam int LAT_STORE_W   = 2;
    localparam int LAT_STORE_SUB = 3;
    localparam int LAT_ERR       = 1;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational lane extract/extend for loads and lane merge for sub-word stores
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] ld_word_i,
    input  logic [1:0]  offset_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] ld_data_o,
    input  logic [31:0] st_old_i,
    input  logic [31:0] st_data_i,
    output logic [31:0] st_word_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = ld_word_i[{offset_i, 3'b000} +: 8];
        half_sel = offset_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];
        case (size_i)
            SIZE_B:  ld_data_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
            SIZE_H:  ld_data_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
            default: ld_data_o = ld_word_i;
        endcase
    end

    always_comb begin
        st_word_o = st_old_i;
        case (size_i)
            SIZE_B: st_word_o[{offset_i, 3'b000} +: 8] = st_data_i[7:0];
            SIZE_H: begin
                if (offset_i[1]) st_word_o[31:16] = st_data_i[15:0];
                else             st_word_o[15:0]  = st_data_i[15:0];
            end
            default: st_word_o = st_data_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - load/store FSM with alignment/range check and sub-word RMW; LSU_STATS_EN adds response counters
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = 1024,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
`ifdef LSU_STATS_EN
    ,
    output logic [15:0]       stat_loads,
    output logic [15:0]       stat_stores,
    output logic [15:0]       stat_errors
`endif
);

    localparam logic [ADDR_W-3:0] WORDS_LIMIT = (ADDR_W-2)'(MEM_WORDS);

    lsu_state_e        state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              req_err;
    logic [31:0]       ld_data;
    logic [31:0]       st_word;

    assign req_err = (req_size == 2'd3)
                   || (req_size == SIZE_H && req_addr[0])
                   || (req_size == SIZE_W && req_addr[1:0] != 2'b00)
                   || (req_addr[ADDR_W-1:2] >= WORDS_LIMIT);

    lsu_align u_align (
        .ld_word_i  (mem_rdata),
        .offset_i   (addr_q[1:0]),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .ld_data_o  (ld_data),
        .st_old_i   (mem_rdata),
        .st_data_i  (wdata_q),
        .st_word_o  (st_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            size_q  <= SIZE_B;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    err_d   = req_err;
                    if (req_err)               state_d = RESP;
                    else if (!req_we)          state_d = LOAD;
                    else if (req_size == SIZE_W) state_d = WR;
                    else                       state_d = RMW_RD;
                end
            end
            LOAD: begin
                rdata_d = ld_data;
                state_d = RESP;
            end
            RMW_RD: begin
                // wdata_q now carries the merged word into WR
                wdata_d = st_word;
                state_d = WR;
            end
            WR:      state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == IDLE);
        rsp_valid = (state_q == RESP);
        rsp_rdata = (state_q == RESP) ? rdata_q : '0;
        rsp_err   = (state_q == RESP) ? err_q : 1'b0;
        mem_read  = (state_q == LOAD) || (state_q == RMW_RD);
        mem_write = (state_q == WR);
        mem_addr  = (mem_read || mem_write) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
        mem_wdata = (state_q == WR) ? wdata_q : '0;
    end

`ifdef LSU_STATS_EN
    logic [15:0] loads_q, stores_q, errors_q;
    logic        rsp_hs;

    assign rsp_hs = (state_q == RESP) && rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loads_q  <= '0;
            stores_q <= '0;
            errors_q <= '0;
        end else if (rsp_hs) begin
            if (err_q) begin
                if (errors_q != 16'hFFFF) errors_q <= errors_q + 16'd1;
            end else if (we_q) begin
                if (stores_q != 16'hFFFF) stores_q <= stores_q + 16'd1;
            end else begin
                if (loads_q != 16'hFFFF) loads_q <= loads_q + 16'd1;
            end
        end
    end

    assign stat_loads  = loads_q;
    assign stat_stores = stores_q;
    assign stat_errors = errors_q;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench with a word-array memory model for load_store_unit
module tb_load_store_unit;

    localparam int MEM_WORDS = 1024;
    localparam int ADDR_W    = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef LSU_STATS_EN
    logic [15:0] stat_loads, stat_stores, stat_errors;
`endif

    logic [31:0] dmem    [MEM_WORDS];
    logic [31:0] ref_mem [MEM_WORDS];
    int errors = 0;
    int checks = 0;
    int n_loads = 0, n_stores = 0, n_errors = 0;
    logic [31:0] got_rdata, got_wdata;
    logic        got_err;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_WORDS(MEM_WORDS), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
`ifdef LSU_STATS_EN
        ,
        .stat_loads   (stat_loads),
        .stat_stores  (stat_stores),
        .stat_errors  (stat_errors)
`endif
    );

    assign mem_rdata = dmem[mem_addr[11:2]];
    always @(posedge clk) if (mem_write) dmem[mem_addr[11:2]] <= mem_wdata;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic preset(input logic [31:0] addr, input logic [31:0] word);
        dmem[addr[11:2]]    = word;
        ref_mem[addr[11:2]] = word;
    endtask

    // Model: compute the response and memory traffic from byte-lane arithmetic, then run the request.
    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata, input int hold);
        logic [31:0] old, shifted, mask, exp_word, exp_rdata, waddr;
        logic        exp_err, rd1;
        int          lat, wr_cyc, sh;
        exp_err = (size == 2'd3) || (size == 2'd1 && addr[0])
               || (size == 2'd2 && addr[1:0] != 2'b00) || ((addr >> 2) >= MEM_WORDS);
        exp_rdata = 32'h0;
        exp_word  = 32'h0;
        lat = 1; wr_cyc = 0; rd1 = 1'b0;
        sh = 8 * int'(addr[1:0]);
        waddr = addr & 32'hFFFF_FFFC;
        if (!exp_err) begin
            old = ref_mem[addr[11:2]];
            if (!we) begin
                lat = 2; rd1 = 1'b1;
                shifted = old >> sh;
                if (size == 2'd0) begin
                    exp_rdata = shifted & 32'hFF;
                    if (!uns && exp_rdata[7]) exp_rdata = exp_rdata | 32'hFFFF_FF00;
                end else if (size == 2'd1) begin
                    exp_rdata = shifted & 32'hFFFF;
                    if (!uns && exp_rdata[15]) exp_rdata = exp_rdata | 32'hFFFF_0000;
                end else begin
                    exp_rdata = old;
                end
            end else begin
                mask = (size == 2'd0) ? 32'hFF : (size == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
                mask = mask << sh;
                exp_word = (old & ~mask) | ((wdata << sh) & mask);
                ref_mem[addr[11:2]] = exp_word;
                if (size == 2'd2) begin lat = 2; wr_cyc = 1; end
                else begin lat = 3; rd1 = 1'b1; wr_cyc = 2; end
            end
        end
        chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
        req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            chk("rsp_valid_timing", {31'b0, rsp_valid}, {31'b0, c == lat});
            chk("req_ready_busy", {31'b0, req_ready}, 32'd0);
            chk("mem_read", {31'b0, mem_read}, {31'b0, rd1 && c == 1});
            chk("mem_write", {31'b0, mem_write}, {31'b0, c == wr_cyc});
            if ((rd1 && c == 1) || c == wr_cyc) chk("mem_addr", mem_addr, waddr);
            if (c == wr_cyc) begin
                chk("mem_wdata", mem_wdata, exp_word);
                got_wdata = mem_wdata;
            end
        end
        chk("rsp_rdata", rsp_rdata, exp_rdata);
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, exp_err});
        got_rdata = rsp_rdata;
        got_err   = rsp_err;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_rsp_valid", {31'b0, rsp_valid}, 32'd1);
            chk("hold_rsp_rdata", rsp_rdata, exp_rdata);
            chk("hold_rsp_err", {31'b0, rsp_err}, {31'b0, exp_err});
            chk("hold_req_ready", {31'b0, req_ready}, 32'd0);
            chk("hold_no_mem", {30'b0, mem_read, mem_write}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        if (exp_err) n_errors++;
        else if (we) n_stores++;
        else n_loads++;
        chk("post_hs_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("post_hs_req_ready", {31'b0, req_ready}, 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, {31'b0, req_ready}, 32'd1);
        chk({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
        chk({tag, "_rsp_err"},   {31'b0, rsp_err}, 32'd0);
        chk({tag, "_mem_rw"},    {30'b0, mem_read, mem_write}, 32'd0);
        chk({tag, "_mem_addr"},  mem_addr, 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    endtask

    task automatic chk_stats(input string tag);
`ifdef LSU_STATS_EN
        chk({tag, "_stat_loads"},  {16'b0, stat_loads},  n_loads[31:0]);
        chk({tag, "_stat_stores"}, {16'b0, stat_stores}, n_stores[31:0]);
        chk({tag, "_stat_errors"}, {16'b0, stat_errors}, n_errors[31:0]);
`else
        chk({tag, "_idle"}, {31'b0, req_ready}, 32'd1);
`endif
    endtask

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) begin
            dmem[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 0);
        chk("lit_word_store_wdata", got_wdata, 32'hDEAD_BEEF);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0);
        chk("lit_word_load", got_rdata, 32'hDEAD_BEEF);

        preset(32'h20, 32'h1122_3344);
        do_req(1'b1, 2'd0, 1'b0, 32'h22, 32'h0000_00AA, 0);
        chk("lit_byte_rmw_wdata", got_wdata, 32'h11AA_3344);
        chk("lit_byte_rmw_mem", dmem[8], 32'h11AA_3344);

        preset(32'h30, 32'h0000_F080);
        do_req(1'b0, 2'd0, 1'b0, 32'h30, 32'h0, 0);
        chk("lit_lb_signed", got_rdata, 32'hFFFF_FF80);
        do_req(1'b0, 2'd0, 1'b1, 32'h30, 32'h0, 0);
        chk("lit_lb_unsigned", got_rdata, 32'h0000_0080);
        do_req(1'b0, 2'd1, 1'b0, 32'h30, 32'h0, 0);
        chk("lit_lh_signed", got_rdata, 32'hFFFF_F080);
        do_req(1'b0, 2'd1, 1'b1, 32'h30, 32'h0, 0);
        do_req(1'b0, 2'd0, 1'b0, 32'h31, 32'h0, 0);
        do_req(1'b1, 2'd1, 1'b0, 32'h32, 32'h1234_BEEF, 0);
        do_req(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 0);
        chk("lit_half_store_upper", got_rdata, 32'hBEEF_F080);
        do_req(1'b1, 2'd0, 1'b0, 32'h33, 32'h0000_0077, 0);
        do_req(1'b0, 2'd0, 1'b1, 32'h33, 32'h0, 0);

        do_req(1'b0, 2'd1, 1'b0, 32'h31, 32'h0, 0);
        chk("lit_err_half_mis", {31'b0, got_err}, 32'd1);
        do_req(1'b0, 2'd2, 1'b0, 32'h22, 32'h0, 0);
        do_req(1'b1, 2'd3, 1'b0, 32'h20, 32'h5555_5555, 0);
        chk("lit_err_size3_rdata", got_rdata, 32'd0);
        do_req(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 0);
        chk("lit_err_range", {31'b0, got_err}, 32'd1);
        do_req(1'b1, 2'd2, 1'b0, 32'h1000, 32'h1, 0);
        do_req(1'b1, 2'd2, 1'b0, 32'hFFC, 32'hCAFE_F00D, 0);
        do_req(1'b0, 2'd2, 1'b0, 32'hFFC, 32'h0, 0);
        chk("lit_last_word", got_rdata, 32'hCAFE_F00D);

        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5);
        do_req(1'b0, 2'd1, 1'b1, 32'h32, 32'h0, 3);
        chk_stats("stats");

        // Reset while the byte store sits in its read phase
        preset(32'h40, 32'h5566_7788);
        req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h41; req_wdata = 32'h0000_00AA; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("rst_pre_mem_read", {31'b0, mem_read}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("midrst_no_write", {31'b0, mem_write}, 32'd0);
        end
        rst_n = 1'b1;
        n_loads = 0; n_stores = 0; n_errors = 0;
        #1;
        chk_stats("midrst");
        @(negedge clk);
        chk("midrst_mem_unchanged", dmem[16], 32'h5566_7788);
        @(posedge clk); #1;
        do_req(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 0);
        chk("lit_after_rst_load", got_rdata, 32'h5566_7788);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
